// File: rtl/sa_pkg.sv
// Shared constants, opcodes and injector state encoding for the systolic-array west injector.
package sa_pkg;

    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned INSTR_BIT = 8;
    localparam int unsigned ACT_BIT   = 8;
    localparam int unsigned ACT_LEN_W = 16;

    typedef enum logic [1:0] {
        COMPARE_STORE              = 2'd0,
        MAC_REDUCE_SOUTH_BROADCAST = 2'd1,
        REDUCE_OFFSET_SEND         = 2'd2
    } opcode_e;

    typedef logic [2:0] inj_state_t;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_INSTR  = 3'd1;
    localparam logic [2:0] ST_SEND_CHANGE = 3'd2;
    localparam logic [2:0] ST_STREAM_ACT  = 3'd3;
    localparam logic [2:0] ST_FINISH      = 3'd4;

endpackage

// File: rtl/array_west_injector_if.sv
// Host-side and east-side handshake bundle of the west injector.
interface array_west_injector_if #(
    parameter int unsigned NUM_COLS  = sa_pkg::NUM_COLS,
    parameter int unsigned INSTR_BIT = sa_pkg::INSTR_BIT,
    parameter int unsigned ACT_BIT   = sa_pkg::ACT_BIT
);

    logic [INSTR_BIT-1:0]         prog_instr;
    logic [NUM_COLS-1:0]          prog_mask;
    logic                         prog_valid;
    logic                         prog_ready;

    logic                         start;
    logic [sa_pkg::ACT_LEN_W-1:0] act_len;
    logic                         busy;
    logic                         done;

    logic [ACT_BIT-1:0]           host_act;
    logic                         host_act_valid;
    logic                         host_act_ready;

    logic [INSTR_BIT-1:0]         instr_e;
    logic [NUM_COLS-1:0]          instr_e_valid;
    logic                         instr_e_ready;

    logic                         change_e_instr;
    logic [NUM_COLS-1:0]          change_instr_e_valid;
    logic                         change_instr_e_ready;

    logic [ACT_BIT-1:0]           actout_e;
    logic [NUM_COLS-1:0]          actout_e_valid;
    logic                         actout_e_ready;

    // Injector side
    modport slave (
        input  prog_instr, prog_mask, prog_valid,
        output prog_ready,
        input  start, act_len,
        output busy, done,
        input  host_act, host_act_valid,
        output host_act_ready,
        output instr_e, instr_e_valid,
        input  instr_e_ready,
        output change_e_instr, change_instr_e_valid,
        input  change_instr_e_ready,
        output actout_e, actout_e_valid,
        input  actout_e_ready
    );

    // Host / array side
    modport master (
        output prog_instr, prog_mask, prog_valid,
        input  prog_ready,
        output start, act_len,
        input  busy, done,
        output host_act, host_act_valid,
        input  host_act_ready,
        input  instr_e, instr_e_valid,
        output instr_e_ready,
        input  change_e_instr, change_instr_e_valid,
        output change_instr_e_ready,
        input  actout_e, actout_e_valid,
        output actout_e_ready
    );

endinterface

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop on a full FIFO frees the slot for a same-cycle push.
module sa_sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_ok);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_ok);
        end
    end

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/array_west_injector.sv
// West-edge injector: replays buffered program words east, issues a change token, then streams activations.
module array_west_injector #(
    parameter int unsigned NUM_COLS   = sa_pkg::NUM_COLS,
    parameter int unsigned INSTR_BIT  = sa_pkg::INSTR_BIT,
    parameter int unsigned ACT_BIT    = sa_pkg::ACT_BIT,
    parameter int unsigned PROG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    array_west_injector_if.slave  bus
);

    import sa_pkg::*;

    localparam int unsigned PW = INSTR_BIT + NUM_COLS;
    localparam int unsigned LW = ACT_LEN_W;

    inj_state_t           r_state;
    inj_state_t           w_state_nxt;

    logic [PW-1:0]        w_head;
    logic [INSTR_BIT-1:0] w_head_instr;
    logic [NUM_COLS-1:0]  w_head_mask;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_load_instr;

    logic [INSTR_BIT-1:0] r_instr;
    logic [NUM_COLS-1:0]  r_instr_valid;
    logic [NUM_COLS-1:0]  r_mask_or;
    logic                 r_change;
    logic [NUM_COLS-1:0]  r_change_valid;
    logic [ACT_BIT-1:0]   r_act;
    logic [NUM_COLS-1:0]  r_act_valid;
    logic [LW-1:0]        r_len;
    logic [LW-1:0]        r_cnt;
    logic [LW-1:0]        r_acc;
    logic [LW-1:0]        w_cnt_nxt;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_instr_fire;
    logic                 w_slot_free;
    logic                 w_change_fire;
    logic                 w_act_fire;
    logic                 w_host_ready;
    logic                 w_host_fire;

    sa_sync_fifo #(
        .WIDTH (PW),
        .DEPTH (PROG_DEPTH)
    ) u_prog_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.prog_valid),
        .i_wdata ({bus.prog_mask, bus.prog_instr}),
        .i_pop   (w_load_instr),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head_instr  = w_head[INSTR_BIT-1:0];
    assign w_head_mask   = w_head[PW-1:INSTR_BIT];

    assign w_instr_fire  = (|r_instr_valid) & bus.instr_e_ready;
    assign w_slot_free   = ~(|r_instr_valid) | bus.instr_e_ready;
    assign w_change_fire = r_change & bus.change_instr_e_ready;
    assign w_act_fire    = (|r_act_valid) & bus.actout_e_ready;
    // Never accept more activations than the run asked for.
    assign w_host_ready  = (r_state == ST_STREAM_ACT) & (~(|r_act_valid) | bus.actout_e_ready)
                         & (r_acc < r_len);
    assign w_host_fire   = w_host_ready & bus.host_act_valid;
    assign w_cnt_nxt     = r_cnt + LW'(w_act_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; the change token is only raised once the instruction slot has drained.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_instr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SEND_INSTR;
                end
            end
            ST_SEND_INSTR: begin
                if (w_slot_free) begin
                    if (!w_fifo_empty) begin
                        w_load_instr = 1'b1;
                    end else begin
                        w_state_nxt = ST_SEND_CHANGE;
                    end
                end
            end
            ST_SEND_CHANGE: begin
                if (w_change_fire) begin
                    w_state_nxt = ST_STREAM_ACT;
                end
            end
            ST_STREAM_ACT: begin
                if (w_cnt_nxt == r_len) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr        <= '0;
            r_instr_valid  <= '0;
            r_mask_or      <= '0;
            r_change       <= 1'b0;
            r_change_valid <= '0;
            r_act          <= '0;
            r_act_valid    <= '0;
            r_len          <= '0;
            r_cnt          <= '0;
            r_acc          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && bus.start) begin
                r_len     <= bus.act_len;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_mask_or <= '0;
                r_busy    <= 1'b1;
            end

            if (w_load_instr) begin
                r_instr       <= w_head_instr;
                r_instr_valid <= w_head_mask;
                r_mask_or     <= r_mask_or | w_head_mask;
            end else if (w_instr_fire) begin
                r_instr_valid <= '0;
            end

            if ((r_state == ST_SEND_INSTR) && (w_state_nxt == ST_SEND_CHANGE)) begin
                r_change       <= 1'b1;
                r_change_valid <= r_mask_or;
            end else if ((r_state == ST_SEND_CHANGE) && w_change_fire) begin
                r_change       <= 1'b0;
                r_change_valid <= '0;
            end

            if (w_host_fire) begin
                r_act       <= bus.host_act;
                r_act_valid <= '1;
                r_acc       <= r_acc + LW'(1);
            end else if (w_act_fire) begin
                r_act_valid <= '0;
            end

            if (r_state == ST_STREAM_ACT) begin
                r_cnt <= w_cnt_nxt;
            end

            r_done <= (r_state == ST_STREAM_ACT) && (w_state_nxt == ST_FINISH);

            if (r_state == ST_FINISH) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.prog_ready           = ~w_fifo_full;
    assign bus.busy                 = r_busy;
    assign bus.done                 = r_done;
    assign bus.host_act_ready       = w_host_ready;
    assign bus.instr_e              = r_instr;
    assign bus.instr_e_valid        = r_instr_valid;
    assign bus.change_e_instr       = r_change;
    assign bus.change_instr_e_valid = r_change_valid;
    assign bus.actout_e             = r_act;
    assign bus.actout_e_valid       = r_act_valid;

endmodule

// File: tb/tb_array_west_injector.sv
// Directed bench for array_west_injector: program replay, stalls, full buffer, empty run, mid-stream reset.
module tb_array_west_injector;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    array_west_injector_if #(.NUM_COLS(4), .INSTR_BIT(8), .ACT_BIT(8)) bus ();

    array_west_injector #(
        .NUM_COLS   (4),
        .INSTR_BIT  (8),
        .ACT_BIT    (8),
        .PROG_DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] q_instr[$];
    logic [3:0]  q_change[$];
    logic [7:0]  q_act[$];
    int          done_cnt;
    int          act_mask_bad;
    int          cyc = 0;
    int          last_instr_cyc;
    int          first_change_cyc;
    logic        acc_pending = 1'b0;

    // East-side transfer recorder, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        acc_pending = bus.host_act_valid & bus.host_act_ready;
        if (!rst) begin
            if ((|bus.instr_e_valid) && bus.instr_e_ready) begin
                q_instr.push_back({bus.instr_e_valid, bus.instr_e});
                last_instr_cyc = cyc;
            end
            if (bus.change_e_instr && bus.change_instr_e_ready) begin
                q_change.push_back(bus.change_instr_e_valid);
                if (first_change_cyc < 0) first_change_cyc = cyc;
            end
            if ((|bus.actout_e_valid) && bus.actout_e_ready) begin
                q_act.push_back(bus.actout_e);
                if (bus.actout_e_valid !== 4'hF) act_mask_bad++;
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    // Host activation source: next value after each accepted one
    always @(posedge clk) begin
        #1;
        if (acc_pending) bus.host_act = bus.host_act + 8'd1;
    end

    task automatic clear_mon();
        q_instr.delete();
        q_change.delete();
        q_act.delete();
        done_cnt         = 0;
        act_mask_bad     = 0;
        last_instr_cyc   = -1;
        first_change_cyc = -1;
    endtask

    task automatic push_word(input logic [7:0] instr, input logic [3:0] mask);
        bus.prog_instr = instr;
        bus.prog_mask  = mask;
        bus.prog_valid = 1'b1;
        @(posedge clk); #1;
        bus.prog_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        bus.act_len = len;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.instr_e_valid !== 4'h0 || bus.instr_e !== 8'h00) begin
            n_fail++; $display("FAIL rst_instr: got valid=%h instr=%h, want 0/00", bus.instr_e_valid, bus.instr_e);
        end
        n_checks++;
        if (bus.change_e_instr !== 1'b0 || bus.change_instr_e_valid !== 4'h0) begin
            n_fail++; $display("FAIL rst_change: got %b/%h, want 0/0", bus.change_e_instr, bus.change_instr_e_valid);
        end
        n_checks++;
        if (bus.actout_e_valid !== 4'h0 || bus.actout_e !== 8'h00) begin
            n_fail++; $display("FAIL rst_act: got valid=%h act=%h, want 0/00", bus.actout_e_valid, bus.actout_e);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy_done: got busy=%b done=%b, want 0/0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.prog_ready !== 1'b1 || bus.host_act_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready: got prog_ready=%b host_act_ready=%b, want 1/0", bus.prog_ready, bus.host_act_ready);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic(input string tag);
        logic [11:0] exp_i [3];
        bit ok;
        exp_i = '{12'h111, 12'h222, 12'hF33};
        clear_mon();
        push_word(8'h11, 4'b0001);
        push_word(8'h22, 4'b0010);
        push_word(8'h33, 4'b1111);
        bus.host_act       = 8'hA0;
        bus.host_act_valid = 1'b1;
        pulse_start(16'd4);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL %s_busy_run: got %b, want 1", tag, bus.busy);
        end
        wait_done(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL %s_done_timeout: got no done, want done within 60 cycles", tag);
        end
        @(posedge clk); #1;
        bus.host_act_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_busy_after: got %b, want 0", tag, bus.busy);
        end
        n_checks++;
        if (q_instr.size() != 3) begin
            n_fail++; $display("FAIL %s_instr_count: got %0d, want 3", tag, q_instr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (q_instr[i] !== exp_i[i]) begin
                    n_fail++; $display("FAIL %s_instr_%0d: got %h, want %h", tag, i, q_instr[i], exp_i[i]);
                end
            end
        end
        n_checks++;
        if (q_change.size() != 1 || q_change[0] !== 4'hF) begin
            n_fail++; $display("FAIL %s_change: got %0d tokens first=%h, want 1 token F", tag, q_change.size(), (q_change.size() > 0) ? q_change[0] : 4'hx);
        end
        n_checks++;
        if (first_change_cyc <= last_instr_cyc) begin
            n_fail++; $display("FAIL %s_change_order: got change cyc %0d, last instr cyc %0d, want later", tag, first_change_cyc, last_instr_cyc);
        end
        n_checks++;
        if (q_act.size() != 4) begin
            n_fail++; $display("FAIL %s_act_count: got %0d, want 4", tag, q_act.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_act[i] !== 8'hA0 + 8'(i)) begin
                    n_fail++; $display("FAIL %s_act_%0d: got %h, want %h", tag, i, q_act[i], 8'hA0 + 8'(i));
                end
            end
        end
        n_checks++;
        if (act_mask_bad != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL %s_mask_done: got bad masks=%0d done pulses=%0d, want 0/1", tag, act_mask_bad, done_cnt);
        end
    endtask

    task automatic test_stall();
        logic [7:0] v_i;
        logic [3:0] v_m;
        bit ok;
        bit seen;
        clear_mon();
        push_word(8'hA1, 4'b0001);
        push_word(8'hB2, 4'b0010);
        push_word(8'hC3, 4'b0100);
        bus.instr_e_ready  = 1'b0;
        bus.host_act       = 8'hA0;
        bus.host_act_valid = 1'b1;
        pulse_start(16'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (|bus.instr_e_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL stall_present: got no valid word, want one within 10 cycles");
        end
        v_i = bus.instr_e;
        v_m = bus.instr_e_valid;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.instr_e_valid, bus.instr_e} !== {v_m, v_i} || v_m !== 4'b0001 || v_i !== 8'hA1) begin
                n_fail++; $display("FAIL stall_hold_%0d: got %h/%h, want 1/a1", k, bus.instr_e_valid, bus.instr_e);
            end
        end
        bus.instr_e_ready = 1'b1;
        wait_done(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL stall_done_timeout: got no done, want done within 60 cycles");
        end
        @(posedge clk); #1;
        bus.host_act_valid = 1'b0;
        n_checks++;
        if (q_instr.size() != 3 || q_instr[0] !== 12'h1A1 || q_instr[1] !== 12'h2B2 || q_instr[2] !== 12'h4C3) begin
            n_fail++; $display("FAIL stall_words: got %0d words %p, want 1a1 2b2 4c3", q_instr.size(), q_instr);
        end
        n_checks++;
        if (q_change.size() != 1 || q_change[0] !== 4'h7 || q_act.size() != 1 || q_act[0] !== 8'hA0) begin
            n_fail++; $display("FAIL stall_tail: got change %p act %p, want 7 and a0", q_change, q_act);
        end
    endtask

    task automatic test_full();
        bit ok;
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_checks++;
                if (bus.prog_ready !== 1'b1) begin
                    n_fail++; $display("FAIL full_ready_7: got %b, want 1", bus.prog_ready);
                end
            end
            push_word(8'h40 + 8'(i), 4'b0001 << (i % 4));
        end
        n_checks++;
        if (bus.prog_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_8: got %b, want 0", bus.prog_ready);
        end
        push_word(8'h99, 4'b0001);
        n_checks++;
        if (bus.prog_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_9: got %b, want 0", bus.prog_ready);
        end
        pulse_start(16'd0);
        wait_done(60, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL full_done_timeout: got no done, want done within 60 cycles");
        end
        @(posedge clk); #1;
        n_checks++;
        if (q_instr.size() != 8) begin
            n_fail++; $display("FAIL full_drain_count: got %0d, want 8", q_instr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (q_instr[i] !== {4'b0001 << (i % 4), 8'h40 + 8'(i)}) begin
                    n_fail++; $display("FAIL full_drain_%0d: got %h, want %h", i, q_instr[i], {4'b0001 << (i % 4), 8'h40 + 8'(i)});
                end
            end
        end
        n_checks++;
        if (bus.prog_ready !== 1'b1 || q_change.size() != 1 || q_change[0] !== 4'hF) begin
            n_fail++; $display("FAIL full_after: got prog_ready=%b change %p, want 1 and F", bus.prog_ready, q_change);
        end
    endtask

    task automatic test_empty();
        bit found;
        clear_mon();
        bus.host_act       = 8'hA0;
        bus.host_act_valid = 1'b1;
        bus.act_len        = 16'd0;
        bus.start          = 1'b1;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL empty_done_4: got no done within 4 cycles, want done");
        end
        repeat (3) @(posedge clk);
        #1;
        bus.host_act_valid = 1'b0;
        n_checks++;
        if (q_change.size() != 1 || q_change[0] !== 4'h0) begin
            n_fail++; $display("FAIL empty_change: got %p, want single 0", q_change);
        end
        n_checks++;
        if (q_act.size() != 0 || q_instr.size() != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL empty_quiet: got acts=%0d instrs=%0d dones=%0d, want 0/0/1", q_act.size(), q_instr.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_mon();
        push_word(8'h55, 4'b0011);
        bus.host_act       = 8'hA0;
        bus.host_act_valid = 1'b1;
        pulse_start(16'd6);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (q_act.size() >= 2) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rmid_two_acts: got %0d acts, want 2 within 60 cycles", q_act.size());
        end
        bus.actout_e_ready = 1'b0;
        push_word(8'h77, 4'b0001);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.instr_e_valid !== 4'h0 || bus.change_instr_e_valid !== 4'h0 || bus.actout_e_valid !== 4'h0) begin
            n_fail++; $display("FAIL rmid_valids: got %h/%h/%h, want 0/0/0", bus.instr_e_valid, bus.change_instr_e_valid, bus.actout_e_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.change_e_instr !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ctrl: got busy=%b done=%b chg=%b, want 0/0/0", bus.busy, bus.done, bus.change_e_instr);
        end
        n_checks++;
        if (bus.prog_ready !== 1'b1 || bus.host_act_ready !== 1'b0) begin
            n_fail++; $display("FAIL rmid_ready: got prog_ready=%b host_act_ready=%b, want 1/0", bus.prog_ready, bus.host_act_ready);
        end
        bus.host_act_valid = 1'b0;
        bus.actout_e_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_basic("post_rst");
    endtask

    initial begin
        rst                      = 1'b1;
        bus.prog_instr           = '0;
        bus.prog_mask            = '0;
        bus.prog_valid           = 1'b0;
        bus.start                = 1'b0;
        bus.act_len              = '0;
        bus.host_act             = '0;
        bus.host_act_valid       = 1'b0;
        bus.instr_e_ready        = 1'b1;
        bus.change_instr_e_ready = 1'b1;
        bus.actout_e_ready       = 1'b1;
        clear_mon();

        test_reset();
        test_basic("basic");
        test_stall();
        test_full();
        test_empty();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/array_west_injector.md
ARRAY_WEST_INJECTOR -- requirements
Module: array_west_injector

Interface
REQ-001 SHALL have parameters: NUM_COLS, default 4, number of PE columns addressed by one-hot valid masks.
REQ-002 SHALL have parameters: INSTR_BIT, default 8, instruction word width; ACT_BIT, default 8, activation width; PROG_DEPTH, default 8, program buffer entries (power of 2).
REQ-003 SHALL have ports (clock and reset first): clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have host program ports: prog_instr  in  INSTR_BIT  instruction word; prog_mask  in  NUM_COLS  target-PE one-hot/multi-hot mask; prog_valid  in  1; prog_ready  out  1 (buffer not full).
REQ-005 SHALL have control ports: start  in  1  one-cycle launch pulse; act_len  in  16  activations to stream after launch; busy  out  1; done  out  1  one-cycle completion pulse.
REQ-006 SHALL have host activation ports: host_act  in  ACT_BIT; host_act_valid  in  1; host_act_ready  out  1.
REQ-007 SHALL have east instruction ports: instr_e  out  INSTR_BIT; instr_e_valid  out  NUM_COLS  target mask; instr_e_ready  in  1.
REQ-008 SHALL have east control ports: change_e_instr  out  1; change_instr_e_valid  out  NUM_COLS; change_instr_e_ready  in  1.
REQ-009 SHALL have east activation ports: actout_e  out  ACT_BIT; actout_e_valid  out  NUM_COLS; actout_e_ready  in  1.

Function
REQ-010 SHALL buffer host program words (instr + mask) in a PROG_DEPTH FIFO; push on prog_valid & prog_ready; prog_ready low only when full; push while full ignored.
REQ-011 SHALL implement FSM states IDLE, SEND_INSTR, SEND_CHANGE, STREAM_ACT, FINISH.
REQ-012 IDLE->SEND_INSTR on start; start ignored outside IDLE; act_len latched at start.
REQ-013 SEND_INSTR: pop FIFO head into registered instr_e / instr_e_valid=mask; hold both stable until a cycle with instr_e_valid!=0 & instr_e_ready; next word presented the following cycle (max one word per 2 cycles acceptable, one per cycle preferred).
REQ-014 SEND_INSTR->SEND_CHANGE when FIFO empty and no word outstanding; an empty FIFO at start passes straight to SEND_CHANGE after one cycle.
REQ-015 SEND_CHANGE: drive change_e_instr=1, change_instr_e_valid = OR of all masks sent this run; hold until change_instr_e_ready; then deassert and go to STREAM_ACT; change token SHALL never precede the last instruction transfer.
REQ-016 STREAM_ACT: register host_act to actout_e with actout_e_valid = all-ones mask; host_act_ready = (output register empty) | actout_e_ready; 16-bit counter increments per east transfer; exit to FINISH when count reaches act_len; act_len=0 exits immediately.
REQ-017 FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE; busy=1 in every other non-IDLE state.
REQ-018 host_act_ready SHALL be 0 outside STREAM_ACT; prog pushes SHALL be accepted in every state, including concurrent pop in SEND_INSTR (simultaneous push/pop on full FIFO: pop then push, count unchanged).
REQ-019 FIFO pointers SHALL carry one extra wrap bit; full = MSBs differ and index bits equal; empty = pointers equal.

Reset
REQ-020 On rst assertion (any cycle, mid-transfer included) SHALL asynchronously clear: FSM to IDLE, FIFO pointers, counter, all *_valid outputs, instr_e, actout_e, change_e_instr, done, busy to 0; prog_ready to 1.
REQ-021 First valid output SHALL not appear earlier than the second clk edge after rst deasserts.

Structure
REQ-022 Package sa_pkg SHALL hold NUM_COLS, INSTR_BIT, ACT_BIT, opcode enum (COMPARE_STORE, MAC_REDUCE_SOUTH_BROADCAST, REDUCE_OFFSET_SEND) and injector state typedef.
REQ-023 Program buffer SHALL be a sub-module sa_sync_fifo (parameterised width/depth, same clk/rst).

Verification
REQ-024 Push 3 words (0x11/0001, 0x22/0010, 0x33/1111), start, act_len=4, ready always 1 -> east instr order 0x11,0x22,0x33 with those masks, then one change token valid=1111, then 4 acts, done pulse once.
REQ-025 instr_e_ready low 5 cycles mid-word -> instr_e/instr_e_valid stable all 5 cycles, no duplicate or dropped word.
REQ-026 Push 9 words with PROG_DEPTH=8, no start -> prog_ready low after 8th, 9th not stored; start drains exactly 8.
REQ-027 start with empty FIFO, act_len=0 -> single change token valid=0000, done within 4 cycles, no actout_e_valid.
REQ-028 rst asserted during STREAM_ACT after 2 of 6 acts -> all valids 0 same cycle, busy 0, FIFO empty; new run behaves as REQ-024.
